// File: rtl/dffrs_pipe_stage.sv
// One register slice of dffrs_pipe: a data/valid pair with a local ready term.
// A stage loads when it is empty or when the stage after it is moving.
module dffrs_pipe_stage #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  dn_ready,
  output logic                  rdy,
  output logic                  q_valid,
  output logic [DATA_WIDTH-1:0] q_data
);

  // An empty stage accepts even while downstream is stalled, so bubbles collapse.
  assign rdy = !q_valid | dn_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_valid <= 1'b0;
      q_data  <= RST_VAL;
    end else if (flush) begin
      q_valid <= 1'b0;
      q_data  <= RST_VAL;
    end else if (rdy) begin
      q_valid <= up_valid;
      if (up_valid) begin
        q_data <= up_data;
      end
    end
  end

endmodule

// File: rtl/dffrs_pipe.sv
// Multi-stage valid/ready register pipeline with async reset, synchronous flush
// and a registered occupancy count.
module dffrs_pipe #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = {DATA_WIDTH{1'b1}},
  localparam int                   CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      occupancy
);

  logic [DEPTH-1:0]      vld;
  logic                  rdy  [DEPTH];
  logic [DATA_WIDTH-1:0] data [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic                  up_v;
      logic [DATA_WIDTH-1:0] up_d;
      logic                  dn_r;

      if (gi == 0) begin : g_head
        assign up_v = in_valid;
        assign up_d = in_data;
      end else begin : g_body
        assign up_v = vld[gi-1];
        assign up_d = data[gi-1];
      end

      if (gi == DEPTH - 1) begin : g_tail
        assign dn_r = out_ready;
      end else begin : g_mid
        assign dn_r = rdy[gi+1];
      end

      dffrs_pipe_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .RST_VAL    (RST_VAL)
      ) u_stage (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .up_valid (up_v),
        .up_data  (up_d),
        .dn_ready (dn_r),
        .rdy      (rdy[gi]),
        .q_valid  (vld[gi]),
        .q_data   (data[gi])
      );
    end
  endgenerate

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  logic in_acc;
  logic out_xfer;

  assign in_acc   = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Tracks popcount(vld) incrementally rather than recounting every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_acc && !out_xfer) begin
      occupancy <= occupancy + 1'b1;
    end else if (!in_acc && out_xfer) begin
      occupancy <= occupancy - 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (occupancy == CNT_W'($countones(vld)));
    end
  end
`endif

endmodule

// File: tb/tb_dffrs_pipe.sv
// Directed and random valid/ready checks of dffrs_pipe at DEPTH=3 (RST_VAL=FFFF)
// and DEPTH=1 (RST_VAL=0).
module tb_dffrs_pipe;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0]  a_in_data, a_out_data;
  logic [1:0]    a_occ;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0]  b_in_data, b_out_data;
  logic [0:0]    b_occ;

  dffrs_pipe #(.DATA_WIDTH(W), .DEPTH(3), .RST_VAL(16'hFFFF)) u_dut_a (
    .clk(clk), .rstn(rstn), .flush(a_flush),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .occupancy(a_occ)
  );

  dffrs_pipe #(.DATA_WIDTH(W), .DEPTH(1), .RST_VAL(16'h0000)) u_dut_b (
    .clk(clk), .rstn(rstn), .flush(b_flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .occupancy(b_occ)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] exp_words [3];
  logic         a_acc, a_xfer, b_acc, b_xfer;

  initial begin
    rstn = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_data", a_out_data, 16'hFFFF);
    check("rst_a_occ", a_occ, 0);
    check("rst_b_data", b_out_data, 16'h0000);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_in_ready", b_in_ready, 1);
    tick();

    // Streaming 0x0001..0x0010, out_ready held high
    a_out_ready = 1'b1;
    for (int j = 0; j < 19; j++) begin
      int cnt;
      logic ev;
      a_in_valid = (j < 16);
      a_in_data  = 16'(j + 1);
      #1;
      if (j < 16) check("stream_in_ready", a_in_ready, 1);
      tick();
      ev = (j >= 2) && (j <= 17);
      check("stream_valid", a_out_valid, ev);
      if (ev) begin
        check("stream_data", a_out_data, j - 1);
        $display("stream: out word %04h occ %0d", a_out_data, a_occ);
      end
      cnt = 0;
      for (int w = j - 2; w <= j; w++) if (w >= 0 && w <= 15) cnt++;
      check("stream_occ", a_occ, cnt);
    end
    a_in_valid = 1'b0;

    // Backpressure: fill while stalled, then release
    exp_words[0] = 16'h00A1; exp_words[1] = 16'h00A2; exp_words[2] = 16'h00A3;
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = exp_words[k];
      #1;
      check("bp_fill_in_ready", a_in_ready, 1);
      tick();
      check("bp_fill_occ", a_occ, k + 1);
      $display("backpressure: accepted %04h", exp_words[k]);
    end
    a_in_data = 16'h00A4;
    #1;
    check("bp_full_in_ready", a_in_ready, 0);
    tick();
    check("bp_hold_occ", a_occ, 3);
    check("bp_hold_data", a_out_data, 16'h00A1);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", a_in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      check("bp_drain_valid", a_out_valid, 1);
      check("bp_drain_data", a_out_data, exp_words[k]);
      $display("backpressure: out word %04h", a_out_data);
      tick();
    end
    check("bp_empty_valid", a_out_valid, 0);
    check("bp_empty_occ", a_occ, 0);

    // Bubble collapse: B1, two idle cycles, B2, one more idle, all stalled
    a_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_in_valid = (k == 0) || (k == 3);
      a_in_data  = (k == 0) ? 16'h00B1 : 16'h00B2;
      #1;
      check("bubble_in_ready", a_in_ready, 1);
      tick();
      check("bubble_occ", a_occ, (k < 3) ? 1 : 2);
      check("bubble_valid", a_out_valid, (k >= 2) ? 1 : 0);
    end
    a_in_valid = 1'b0;
    check("bubble_hold_data", a_out_data, 16'h00B1);
    a_out_ready = 1'b1;
    tick();
    check("bubble_b2_valid", a_out_valid, 1);
    check("bubble_b2_data", a_out_data, 16'h00B2);
    $display("bubble: out word %04h after B1", a_out_data);
    check("bubble_b2_occ", a_occ, 1);
    tick();
    check("bubble_done_valid", a_out_valid, 0);

    // Flush on a full pipe drops the concurrent input
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 16'h00D1 + 16'(k);
      tick();
    end
    check("flush_pre_occ", a_occ, 3);
    a_flush    = 1'b1;
    a_in_data  = 16'h00C0;
    #1;
    check("flush_in_ready", a_in_ready, 0);
    tick();
    a_flush = 1'b0;
    check("flush_occ", a_occ, 0);
    check("flush_valid", a_out_valid, 0);
    check("flush_data", a_out_data, 16'hFFFF);
    $display("flush: pipe cleared, occ %0d", a_occ);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("flush_no_c0", a_out_valid, 0);
    end

    // Asynchronous reset mid-clock with words in flight
    a_out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 16'h00E1 + 16'(k);
      tick();
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b1;
    b_in_data  = 16'h1234;
    tick();
    b_in_valid = 1'b0;
    check("arst_pre_occ", a_occ, 2);
    check("arst_pre_b_data", b_out_data, 16'h1234);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid", a_out_valid, 0);
    check("arst_data", a_out_data, 16'hFFFF);
    check("arst_occ", a_occ, 0);
    check("arst_b_data", b_out_data, 16'h0000);
    check("arst_b_valid", b_out_valid, 0);
    $display("async reset: state cleared mid-cycle");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("arst_rel_in_ready", a_in_ready, 1);
    tick();
    check("arst_rel_valid", a_out_valid, 0);
    check("arst_rel_occ", a_occ, 0);

    // Random traffic on both instances against queue scoreboards
    for (int c = 0; c < 10006; c++) begin
      if (c < 10000) begin
        a_in_valid  = ($urandom_range(0, 3) != 0);
        a_in_data   = W'($urandom);
        a_out_ready = ($urandom_range(0, 2) != 0);
        a_flush     = ($urandom_range(0, 199) == 0);
        b_in_valid  = ($urandom_range(0, 2) != 0);
        b_in_data   = W'($urandom);
        b_out_ready = ($urandom_range(0, 1) != 0);
        b_flush     = ($urandom_range(0, 199) == 0);
      end else begin
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_flush = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_flush = 1'b0;
      end
      @(negedge clk);
      check("rnd_a_in_ready", a_in_ready, !a_flush && (qa.size() < 3 || a_out_ready));
      check("rnd_b_in_ready", b_in_ready, !b_flush && (qb.size() < 1 || b_out_ready));
      if (a_out_valid) begin
        check("rnd_a_nonempty", qa.size() != 0, 1);
        if (qa.size() != 0) check("rnd_a_data", a_out_data, qa[0]);
      end
      if (b_out_valid) begin
        check("rnd_b_nonempty", qb.size() != 0, 1);
        if (qb.size() != 0) check("rnd_b_data", b_out_data, qb[0]);
      end
      a_acc  = a_in_valid & a_in_ready;
      a_xfer = a_out_valid & a_out_ready;
      b_acc  = b_in_valid & b_in_ready;
      b_xfer = b_out_valid & b_out_ready;
      tick();
      if (a_xfer && qa.size() != 0) void'(qa.pop_front());
      if (a_flush) qa.delete();
      if (a_acc) qa.push_back(a_in_data);
      if (b_xfer && qb.size() != 0) void'(qb.pop_front());
      if (b_flush) qb.delete();
      if (b_acc) qb.push_back(b_in_data);
      check("rnd_a_occ", a_occ, qa.size());
      check("rnd_b_occ", b_occ, qb.size());
    end
    check("rnd_a_drained", a_out_valid, 0);
    check("rnd_b_drained", b_out_valid, 0);
    $display("random: 10000 cycles on DEPTH=3 and DEPTH=1 completed");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
